// File: rtl/serial_adder_if.sv
// Operand/result bundle between an operand source and serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one bit per clock through two cascaded half adders
// and a registered carry. Optional signed overflow output via SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Per-bit datapath: first half adder on (x,y), second on (partial sum, carry).
    logic             ha1_s, ha1_c, ha2_s, ha2_c, c_next;
    logic [WIDTH-1:0] s_shift;

    always_comb begin
        ha1_s   = a_q[0] ^ b_q[0];
        ha1_c   = a_q[0] & b_q[0];
        ha2_s   = ha1_s ^ c_q;
        ha2_c   = ha1_s & c_q;
        c_next  = ha1_c | ha2_c;
        s_shift = {ha2_s, s_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            // DONE accepts a new request just like IDLE for back-to-back adds.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = SHIFT;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                s_d   = s_shift;
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = s_shift;
                    cout_d  = c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = c_q ^ c_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus corner sequences,
// expected results queued at stimulus time and checked at each done pulse.
module tb_serial_adder;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    vec_t     vecs [8];
    exp_t     exp_q [$];
    int       n_tests = 0;
    int       n_fail  = 0;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        e.sum = s; e.cout = c; e.ovf = o;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Returns on the negedge where done is high, without advancing past it.
    task automatic wait_result(input int exp_busy);
        int   busy_cnt = 0;
        int   t = 0;
        logic stable = 1'b1;
        exp_t e;
        while (!bus.done && t < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.sum !== last_sum || bus.cout !== last_cout) stable = 1'b0;
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        check("hold_prev", 32'(stable), 32'd1);
        check("busy_in_done", 32'(bus.busy), 32'd0);
        check("sb_depth", 32'(exp_q.size()), 32'd1);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        last_sum  = bus.sum;
        last_cout = bus.cout;
    endtask

    task automatic no_done(input int n);
        int dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("extra_done", 32'(dones), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[7] = '{8'hC3, 8'h9C, 8'h5F, 1'b1, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum",  32'(bus.sum),  32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf",  32'(bus.ovf),  32'd0);
`endif
        rst_n = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            wait_result(8);
        end
        no_done(3);

        // start during SHIFT is ignored; original result, single done
        do_op(8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        wait_result(5);
        no_done(12);

        // Back-to-back: start held in the DONE cycle
        do_op(8'h22, 8'h11, 8'h33, 1'b0, 1'b0);
        wait_result(8);
        begin
            exp_t e;
            e.sum = 8'h10; e.cout = 1'b0; e.ovf = 1'b0;
            bus.start = 1'b1;
            bus.a     = 8'h0F;
            bus.b     = 8'h01;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'hEE;
        bus.b     = 8'hEE;
        check("b2b_busy_rise", 32'(bus.busy), 32'd1);
        check("b2b_done_low",  32'(bus.done), 32'd0);
        wait_result(8);
        no_done(3);

        // Async reset mid-operation aborts with no done
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        last_sum  = '0;
        last_cout = 1'b0;
        no_done(12);
        do_op(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        wait_result(8);
        no_done(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
